adam_aes_ctr_stream: RTL and testbench
======================================

Name: adam_aes_ctr_stream

Overview:
CTR-mode streaming front-end that sits directly upstream of the pipelined AES core. It accepts 128-bit plaintext/ciphertext blocks on a valid/ready stream and drives the core's start/block/key interface with the running counter block. It XORs each returned keystream block with the buffered input and presents the result on an output valid/ready stream. It processes one block at a time; encryption and decryption are the same operation, so the core is always driven with encdec=1.

Parameters:
CTR_WIDTH, 32, width of the incrementing low field of the counter block (1..128)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cfg_key  input  256  AES key; a 128-bit key occupies [255:128]
cfg_keylen  input  1  0 = 128-bit key, 1 = 256-bit key
cfg_iv  input  128  initial counter block
cfg_load  input  1  one-cycle pulse: latch key, keylen and IV
cfg_ready  output  1  high only in IDLE; cfg_load is honoured only while high
in_valid  input  1  input block valid
in_ready  output  1  input block accepted when in_valid && in_ready
in_data  input  128  input block
in_last  input  1  marks the final block of a message
out_valid  output  1  result valid
out_ready  input  1  downstream accept
out_data  output  128  in_data XOR keystream
out_last  output  1  copy of in_last for this block
core_start  output  1  start pulse to AES core
core_encdec  output  1  constant 1
core_key  output  256  latched key
core_keylen  output  1  latched keylen
core_block  output  128  current counter block
core_ready  input  1  core ready
core_result_valid  input  1  core result valid (level)
core_result  input  128  keystream block
blk_count  output  32  blocks emitted in current message

Behaviour:
- Reset values: state IDLE; ctr_reg, iv-derived registers, key_reg, keylen_reg, data_reg, out_data = 0; out_valid, out_last, core_start, in_ready = 0; blk_count = 0. Reset mid-operation aborts any block and drops any pending output.
- core_key, core_keylen and core_block are registered, and stay stable while a block is in flight.
- The FSM has four states: IDLE, ISSUE, WAIT, OUT.
- IDLE: cfg_ready = 1.
  - If cfg_load = 1: key_reg, keylen_reg and ctr_reg take the cfg values, and blk_count is cleared. cfg_load takes priority, so in_ready = 0 in that cycle.
  - Otherwise in_ready = 1. On an input handshake, data_reg and last_reg are captured and the FSM goes to ISSUE.
- ISSUE: core_start = core_ready (combinational, one cycle). If core_ready = 1, go to WAIT; otherwise stay in ISSUE.
- WAIT: sampling starts the cycle after start (the core clears result_valid at that edge). When core_result_valid = 1:
  - out_data <= data_reg ^ core_result, out_last <= last_reg, out_valid <= 1.
  - ctr_reg[CTR_WIDTH-1:0] increments modulo 2^CTR_WIDTH; the upper bits are unchanged.
  - Go to OUT.
- OUT: out_valid = 1, and out_data/out_last are held until the handshake.
  - in_ready = out_ready. On a simultaneous output and input handshake, the new block is captured and the FSM goes straight to ISSUE (back-to-back). Output handshake alone returns to IDLE.
  - On the output handshake, blk_count increments, or clears to 0 if out_last = 1. blk_count wraps at 2^32.
- cfg_load outside IDLE is ignored with no side effect.
- Counter wrap: low field all-ones → zero with no carry into the upper bits. There is no error flag.
- Latency from input handshake to out_valid = core latency + 2 cycles. There is no bubble in the accept path other than the core time.
- Decrypt uses the identical datapath.

Test Plan:
1. Reset, then cfg_load with keylen=0, key[255:128]=2b7e151628aed2a6abf7158809cf4f3c, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; send 6bc1bee22e409f96e93d7e117393172a → out_data 874d6191b620e3261bef6864990db6ce, core_block = IV, blk_count 0→1.
2. Feed the output of test 1 back with the same key/IV reloaded → out_data 6bc1bee22e409f96e93d7e117393172a (decrypt symmetry).
3. IV low field ffffffff, two blocks → core_block low 32 bits go ffffffff then 00000000, upper 96 bits unchanged.
4. Hold out_ready=0 for 10 cycles after out_valid → out_data/out_last stable, in_ready=0, no core_start, ctr_reg unchanged.
5. Three blocks with in_valid and out_ready always high, last on the third → exactly one core_start per block, blk_count 1,2,0, out_last only on the third.
6. cfg_load pulsed in WAIT, then assert reset_n low in WAIT → the load is ignored (ctr unchanged); after reset all outputs are 0 and the state is IDLE with cfg_ready=1.

Source files
------------

// File: rtl/adam_aes_ctr_stream_if.sv
// Bus bundle for adam_aes_ctr_stream: input stream, output stream and AES core handshake.
// The slave modport is the CTR front-end; the master modport is its environment.
interface adam_aes_ctr_stream_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         core_start;
  logic         core_encdec;
  logic [255:0] core_key;
  logic         core_keylen;
  logic [127:0] core_block;
  logic         core_ready;
  logic         core_result_valid;
  logic [127:0] core_result;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    input  core_ready, core_result_valid, core_result,
    output in_ready, out_valid, out_data, out_last,
    output core_start, core_encdec, core_key, core_keylen, core_block
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    output core_ready, core_result_valid, core_result,
    input  in_ready, out_valid, out_data, out_last,
    input  core_start, core_encdec, core_key, core_keylen, core_block
  );
endinterface

// File: rtl/adam_aes_ctr_stream.sv
// CTR-mode streaming front-end for a pipelined AES core: one block in flight at a time,
// keystream XORed with the buffered input block and presented on a valid/ready output.
module adam_aes_ctr_stream #(
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [255:0]         cfg_key,
  input  logic                 cfg_keylen,
  input  logic [127:0]         cfg_iv,
  input  logic                 cfg_load,
  output logic                 cfg_ready,
  adam_aes_ctr_stream_if.slave bus,
  output logic [31:0]          blk_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Only the low CTR_WIDTH bits of the counter block ever change; upper bits never see a carry.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

  logic [1:0]   state_q, state_d;
  logic [127:0] ctr_q, ctr_d;
  logic [255:0] key_q, key_d;
  logic         keylen_q, keylen_d;
  logic [127:0] data_q, data_d;
  logic         last_q, last_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_last_q, out_last_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  blk_count_q, blk_count_d;
  logic         in_ready_c;
  logic         start_c;

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    key_d       = key_q;
    keylen_d    = keylen_q;
    data_d      = data_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    blk_count_d = blk_count_q;
    in_ready_c  = 1'b0;
    start_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          key_d       = cfg_key;
          keylen_d    = cfg_keylen;
          ctr_d       = cfg_iv;
          blk_count_d = '0;
        end else begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            data_d  = bus.in_data;
            last_d  = bus.in_last;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        start_c = bus.core_ready;
        if (bus.core_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.core_result_valid) begin
          out_data_d  = data_q ^ bus.core_result;
          out_last_d  = last_q;
          out_valid_d = 1'b1;
          ctr_d       = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        // Accepting the next block in the same cycle as the output handshake avoids a bubble.
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          blk_count_d = out_last_q ? 32'd0 : blk_count_q + 32'd1;
          if (bus.in_valid) begin
            data_d  = bus.in_data;
            last_d  = bus.in_last;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ctr_q       <= '0;
      key_q       <= '0;
      keylen_q    <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      data_q      <= data_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      blk_count_q <= blk_count_d;
    end
  end

  // in_ready is forced low while reset is held so no block can be taken during reset.
  assign bus.in_ready    = in_ready_c & reset_n;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.core_start  = start_c;
  assign bus.core_encdec = 1'b1;
  assign bus.core_key    = key_q;
  assign bus.core_keylen = keylen_q;
  assign bus.core_block  = ctr_q;
  assign cfg_ready       = (state_q == ST_IDLE);
  assign blk_count       = blk_count_q;

endmodule

// File: tb/tb_adam_aes_ctr_stream.sv
// Self-checking bench for adam_aes_ctr_stream: a behavioural AES-core stand-in with random
// ready/latency, and a reference model of the counter, key and block count.
module tb_adam_aes_ctr_stream;

  localparam logic [255:0] KAT_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] KAT_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] KAT_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] KAT_CT  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] KAT_KS  = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] cfgKey;
  logic         cfgKeylen;
  logic [127:0] cfgIv;
  logic         cfgLoad;
  logic         cfgReady;
  logic [31:0]  blkCount;

  int testCount = 0;
  int failCount = 0;
  int startCount = 0;
  int blocksSent = 0;
  int fixedLat = 0;
  int coreCnt = 0;
  int budget;
  logic [127:0] corePending;

  logic [255:0] refKey;
  logic         refKeylen;
  logic [127:0] refCtr;
  logic [31:0]  refBlk;
  logic [127:0] streamData [8];
  logic [127:0] lastOut;
  logic [127:0] expData;
  logic         expLast;
  logic [127:0] inflightCtr;
  logic [127:0] blk4;

  adam_aes_ctr_stream_if bus();

  adam_aes_ctr_stream #(.CTR_WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_key    (cfgKey),
    .cfg_keylen (cfgKeylen),
    .cfg_iv     (cfgIv),
    .cfg_load   (cfgLoad),
    .cfg_ready  (cfgReady),
    .bus        (bus),
    .blk_count  (blkCount)
  );

  always #5 clk = ~clk;

  // Keystream of the stand-in core: the real AES answer for the known-answer vector, else a keyed mix.
  function automatic logic [127:0] ksModel(input logic [255:0] k, input logic kl, input logic [127:0] b);
    if (k == KAT_KEY && !kl && b == KAT_IV) return KAT_KS;
    return {b[63:0], b[127:64]} ^ k[255:128] ^ (kl ? k[127:0] : 128'h0) ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic logic [127:0] nextCtr(input logic [127:0] c);
    return {c[127:32], c[31:0] + 32'd1};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in pipelined core: captures the request at start, clears result_valid, answers later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.core_ready        <= 1'b0;
      bus.core_result_valid <= 1'b0;
      bus.core_result       <= '0;
      coreCnt               <= 0;
    end else begin
      bus.core_ready <= ($urandom_range(0, 3) != 0);
      if (bus.core_start) begin
        bus.core_result_valid <= 1'b0;
        coreCnt     <= (fixedLat != 0) ? fixedLat : int'($urandom_range(1, 4));
        corePending <= ksModel(bus.core_key, bus.core_keylen, bus.core_block);
        startCount  <= startCount + 1;
      end else if (coreCnt != 0) begin
        coreCnt <= coreCnt - 1;
        if (coreCnt == 1) begin
          bus.core_result_valid <= 1'b1;
          bus.core_result       <= corePending;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cfg_ready"}, 256'(cfgReady), 256'd1);
    checkOutput({tag, "_in_ready"}, 256'(bus.in_ready), 256'd0);
    checkOutput({tag, "_out_valid"}, 256'(bus.out_valid), 256'd0);
    checkOutput({tag, "_out_data"}, 256'(bus.out_data), 256'd0);
    checkOutput({tag, "_out_last"}, 256'(bus.out_last), 256'd0);
    checkOutput({tag, "_core_start"}, 256'(bus.core_start), 256'd0);
    checkOutput({tag, "_core_encdec"}, 256'(bus.core_encdec), 256'd1);
    checkOutput({tag, "_core_key"}, bus.core_key, 256'd0);
    checkOutput({tag, "_core_keylen"}, 256'(bus.core_keylen), 256'd0);
    checkOutput({tag, "_core_block"}, 256'(bus.core_block), 256'd0);
    checkOutput({tag, "_blk_count"}, 256'(blkCount), 256'd0);
  endtask

  // Pulses cfg_load in IDLE with in_valid also high; the load must win and nothing is accepted.
  task automatic applyStimulus(input logic [255:0] key, input logic keylen, input logic [127:0] iv);
    @(negedge clk);
    cfgKey = key;
    cfgKeylen = keylen;
    cfgIv = iv;
    cfgLoad = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = rand128();
    #1;
    checkOutput("load_in_ready", 256'(bus.in_ready), 256'd0);
    checkOutput("load_cfg_ready", 256'(cfgReady), 256'd1);
    @(negedge clk);
    cfgLoad = 1'b0;
    bus.in_valid = 1'b0;
    refKey = key;
    refKeylen = keylen;
    refCtr = iv;
    refBlk = 32'd0;
    #1;
    checkOutput("load_blk_count", 256'(blkCount), 256'(refBlk));
    checkOutput("load_core_block", 256'(bus.core_block), 256'(iv));
    checkOutput("load_core_key", bus.core_key, key);
    checkOutput("load_core_keylen", 256'(bus.core_keylen), 256'(keylen));
    checkOutput("load_still_idle", 256'(cfgReady), 256'd1);
  endtask

  task automatic runStream(input int nBlocks, input int lastIdx);
    int sent = 0;
    int got = 0;
    int cycles = 0;
    logic outHs = 1'b0;
    while (got < nBlocks && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (outHs) begin
        checkOutput("blk_count", 256'(blkCount), 256'(refBlk));
        outHs = 1'b0;
      end
      bus.in_valid = (sent < nBlocks);
      bus.in_data = streamData[sent % 8];
      bus.in_last = (sent == lastIdx);
      bus.out_ready = 1'b1;
      #1;
      if (bus.core_start) begin
        checkOutput("core_block", 256'(bus.core_block), 256'(inflightCtr));
        checkOutput("core_key", bus.core_key, refKey);
        checkOutput("core_keylen", 256'(bus.core_keylen), 256'(refKeylen));
      end
      if (bus.out_valid) begin
        checkOutput("out_data", 256'(bus.out_data), 256'(expData));
        checkOutput("out_last", 256'(bus.out_last), 256'(expLast));
        lastOut = bus.out_data;
        refBlk = expLast ? 32'd0 : refBlk + 32'd1;
        got++;
        outHs = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) begin
        expData = streamData[sent % 8] ^ ksModel(refKey, refKeylen, refCtr);
        expLast = (sent == lastIdx);
        inflightCtr = refCtr;
        refCtr = nextCtr(refCtr);
        sent++;
        blocksSent++;
      end
    end
    checkOutput("stream_blocks", 256'(got), 256'(nBlocks));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    if (outHs) checkOutput("blk_count", 256'(blkCount), 256'(refBlk));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    cfgKey = '0;
    cfgKeylen = 1'b0;
    cfgIv = '0;
    cfgLoad = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkResetOutputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("idle_in_ready", 256'(bus.in_ready), 256'd1);

    // Known-answer encrypt, then the ciphertext fed back decrypts to the plaintext.
    applyStimulus(KAT_KEY, 1'b0, KAT_IV);
    streamData[0] = KAT_PT;
    runStream(1, -1);
    checkOutput("kat_encrypt", 256'(lastOut), 256'(KAT_CT));
    applyStimulus(KAT_KEY, 1'b0, KAT_IV);
    streamData[0] = KAT_CT;
    runStream(1, -1);
    checkOutput("kat_decrypt", 256'(lastOut), 256'(KAT_PT));

    // Random 256-bit key message of four blocks ending in last.
    for (int i = 0; i < 4; i++) streamData[i] = rand128();
    applyStimulus({rand128(), rand128()}, 1'b1, rand128());
    runStream(4, 3);

    // Low counter field wraps without carrying into the upper 96 bits.
    for (int i = 0; i < 2; i++) streamData[i] = rand128();
    applyStimulus({rand128(), rand128()}, 1'b0, 128'h0123456789abcdef01234567ffffffff);
    runStream(2, 1);
    checkOutput("ctr_wrap", 256'(bus.core_block), 256'(128'h0123456789abcdef0123456700000001));

    // Output back-pressure: everything held, nothing accepted, no extra core traffic.
    applyStimulus({rand128(), rand128()}, 1'b1, rand128());
    blk4 = rand128();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = blk4;
    bus.in_last = 1'b1;
    #1;
    checkOutput("hold_accept", 256'(bus.in_ready), 256'd1);
    expData = blk4 ^ ksModel(refKey, refKeylen, refCtr);
    expLast = 1'b1;
    refCtr = nextCtr(refCtr);
    blocksSent++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    budget = 0;
    while (!bus.out_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("hold_out_valid", 256'(bus.out_valid), 256'd1);
    repeat (10) begin
      @(negedge clk);
      #1;
      checkOutput("hold_out_data", 256'(bus.out_data), 256'(expData));
      checkOutput("hold_out_last", 256'(bus.out_last), 256'(expLast));
      checkOutput("hold_out_valid", 256'(bus.out_valid), 256'd1);
      checkOutput("hold_in_ready", 256'(bus.in_ready), 256'd0);
      checkOutput("hold_ctr", 256'(bus.core_block), 256'(refCtr));
      checkOutput("hold_starts", 256'(startCount), 256'(blocksSent));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("hold_release_in_ready", 256'(bus.in_ready), 256'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    refBlk = 32'd0;
    #1;
    checkOutput("hold_blk_count", 256'(blkCount), 256'(refBlk));
    checkOutput("hold_done_valid", 256'(bus.out_valid), 256'd0);
    checkOutput("hold_idle", 256'(cfgReady), 256'd1);

    // Back-to-back stream, one core start per block, last only on the third.
    fixedLat = 1;
    for (int i = 0; i < 3; i++) streamData[i] = rand128();
    applyStimulus({rand128(), rand128()}, 1'b0, rand128());
    runStream(3, 2);
    checkOutput("b2b_starts", 256'(startCount), 256'(blocksSent));
    fixedLat = 0;

    // cfg_load in WAIT is ignored, then reset in WAIT aborts the block.
    fixedLat = 4;
    applyStimulus({rand128(), rand128()}, 1'b1, rand128());
    @(negedge clk);
    blk4 = rand128();
    bus.in_valid = 1'b1;
    bus.in_data = blk4;
    bus.in_last = 1'b0;
    #1;
    checkOutput("abort_accept", 256'(bus.in_ready), 256'd1);
    inflightCtr = refCtr;
    blocksSent++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    budget = 0;
    while (!bus.core_start && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    checkOutput("abort_start", 256'(bus.core_start), 256'd1);
    @(negedge clk);
    cfgKey = {rand128(), rand128()};
    cfgIv = ~inflightCtr;
    cfgLoad = 1'b1;
    #1;
    checkOutput("wait_cfg_ready", 256'(cfgReady), 256'd0);
    @(negedge clk);
    cfgLoad = 1'b0;
    #1;
    checkOutput("wait_ctr_kept", 256'(bus.core_block), 256'(inflightCtr));
    checkOutput("wait_key_kept", bus.core_key, refKey);
    checkOutput("wait_no_output", 256'(bus.out_valid), 256'd0);
    reset_n = 1'b0;
    #1 checkResetOutputs("abort_rst");
    @(negedge clk);
    reset_n = 1'b1;
    fixedLat = 0;
    #1;
    checkOutput("abort_idle_in_ready", 256'(bus.in_ready), 256'd1);
    checkOutput("abort_idle_cfg_ready", 256'(cfgReady), 256'd1);

    // Normal operation resumes after the aborted block.
    for (int i = 0; i < 2; i++) streamData[i] = rand128();
    applyStimulus({rand128(), rand128()}, 1'b1, rand128());
    runStream(2, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
